// File: rtl/prog_upg_writer.sv
// Program-ROM upgrade writer: parses a length-prefixed byte stream and writes 32-bit words into the ROM.
// Optional feature: define UPG_CHECKSUM_EN to require a trailing XOR checksum byte per session.
module prog_upg_writer #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE
`ifdef UPG_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

  state_t      state, state_d;
  logic [15:0] len;
  logic [15:0] wcnt;
  logic [1:0]  bcnt;
  logic        accept;
  logic [15:0] n_full;
  logic        n_big;
  logic        last_word;
`ifdef UPG_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign accept    = byte_valid & byte_ready;
  assign n_full    = {byte_data, len[7:0]};
  assign n_big     = 32'(n_full) > (32'd1 << ADDR_W);
  assign last_word = (wcnt + 16'd1) == len;

  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE: if (start) state_d = LEN_LO;
      LEN_LO:     if (accept) state_d = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (n_big)
            state_d = DONE;
          else if (n_full == 16'd0)
`ifdef UPG_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          else
            state_d = DATA;
        end
      end
      DATA:  if (accept && bcnt == 2'd3) state_d = WRITE;
      WRITE: begin
        if (last_word)
`ifdef UPG_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = DONE;
`endif
        else
          state_d = DATA;
      end
`ifdef UPG_CHECKSUM_EN
      CSUM:  if (accept) state_d = DONE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_done_o <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      len        <= '0;
      wcnt       <= '0;
      bcnt       <= '0;
`ifdef UPG_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= state_d;
`ifdef UPG_CHECKSUM_EN
      byte_ready <= state_d inside {LEN_LO, LEN_HI, DATA, CSUM};
`else
      byte_ready <= state_d inside {LEN_LO, LEN_HI, DATA};
`endif
      busy       <= !(state_d inside {IDLE, DONE});
      upg_wen_o  <= state_d == WRITE;
      upg_done_o <= state_d == DONE;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            err       <= 1'b0;
            upg_adr_o <= '0;
            wcnt      <= '0;
            bcnt      <= '0;
`ifdef UPG_CHECKSUM_EN
            csum      <= '0;
`endif
          end
        end
        LEN_LO: if (accept) len[7:0] <= byte_data;
        LEN_HI: begin
          if (accept) begin
            len[15:8] <= byte_data;
            if (n_big) err <= 1'b1;
          end
        end
        DATA: begin
          if (accept) begin
            upg_dat_o[{bcnt, 3'b000} +: 8] <= byte_data;
            bcnt <= bcnt + 2'd1;
`ifdef UPG_CHECKSUM_EN
            csum <= csum ^ byte_data;
`endif
          end
        end
        WRITE: begin
          wcnt <= wcnt + 16'd1;
          // Hold the address on the final word so a full-capacity session never wraps.
          if (!last_word) upg_adr_o <= upg_adr_o + ADR_ONE;
        end
`ifdef UPG_CHECKSUM_EN
        CSUM: if (accept && byte_data != csum) err <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule
